// File: rtl/inta_cycle_master.sv
// Host-side 8259A interrupt-acknowledge initiator: two INTA pulses, vector capture, valid/ready hand-off.
// Optional INTA_SPURIOUS_CHK_EN builds the spurious-request qualifier; otherwise spurious is tied low.
module inta_cycle_master #(
    parameter int PULSE_LOW = 2,
    parameter int PULSE_GAP = 2,
    parameter int RECOVER   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       INT,
    input  logic       enable,
    output logic       INTA,
    input  logic [7:0] DATA_IN,
    output logic [7:0] vec_out,
    output logic       vec_valid,
    input  logic       vec_ready,
    output logic       busy,
    output logic       spurious
);
    localparam int MAX_LG = (PULSE_LOW > PULSE_GAP) ? PULSE_LOW : PULSE_GAP;
    localparam int MAX_P  = (MAX_LG > RECOVER) ? MAX_LG : RECOVER;
    localparam int CW     = $clog2(MAX_P + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ACK1    = 3'd1;
    localparam logic [2:0] S_GAP     = 3'd2;
    localparam logic [2:0] S_ACK2    = 3'd3;
    localparam logic [2:0] S_HOLD    = 3'd4;
    localparam logic [2:0] S_RECOVER = 3'd5;

    logic          sync1_q, int_s_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          inta_q, inta_d;
    logic [7:0]    vec_q, vec_d;
    logic          valid_q, valid_d;
`ifdef INTA_SPURIOUS_CHK_EN
    logic          spur_q, spur_d;
    logic          spur_flag_q, spur_flag_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        valid_d = valid_q;
`ifdef INTA_SPURIOUS_CHK_EN
        spur_d      = spur_q;
        spur_flag_d = spur_flag_q;
`endif
        case (state_q)
            S_IDLE: begin
                // enable only gates the start of a sequence, never an ongoing one
                if (int_s_q && enable) begin
                    state_d = S_ACK1;
                    cnt_d   = CW'(PULSE_LOW - 1);
                end
            end
            S_ACK1: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = CW'(PULSE_GAP - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_ACK2;
                    cnt_d   = CW'(PULSE_LOW - 1);
`ifdef INTA_SPURIOUS_CHK_EN
                    spur_flag_d = ~int_s_q;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ACK2: begin
                // Vector is captured on the edge that ends the second pulse
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    vec_d   = DATA_IN;
                    valid_d = 1'b1;
`ifdef INTA_SPURIOUS_CHK_EN
                    spur_d = spur_flag_q;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                if (vec_ready) begin
                    state_d = S_RECOVER;
                    cnt_d   = CW'(RECOVER - 1);
                    valid_d = 1'b0;
`ifdef INTA_SPURIOUS_CHK_EN
                    spur_d = 1'b0;
`endif
                end
            end
            S_RECOVER: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        inta_d = ~((state_d == S_ACK1) || (state_d == S_ACK2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            int_s_q <= 1'b0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            inta_q  <= 1'b1;
            vec_q   <= 8'h00;
            valid_q <= 1'b0;
`ifdef INTA_SPURIOUS_CHK_EN
            spur_q      <= 1'b0;
            spur_flag_q <= 1'b0;
`endif
        end else begin
            sync1_q <= INT;
            int_s_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            inta_q  <= inta_d;
            vec_q   <= vec_d;
            valid_q <= valid_d;
`ifdef INTA_SPURIOUS_CHK_EN
            spur_q      <= spur_d;
            spur_flag_q <= spur_flag_d;
`endif
        end
    end

    assign INTA      = inta_q;
    assign vec_out   = vec_q;
    assign vec_valid = valid_q;
    assign busy      = (state_q != S_IDLE);
`ifdef INTA_SPURIOUS_CHK_EN
    assign spurious = spur_q;
`else
    assign spurious = 1'b0;
`endif

endmodule

// File: tb/tb_inta_cycle_master.sv
// Randomized bench for inta_cycle_master against a timeline model of the acknowledge protocol.
// Honours INTA_SPURIOUS_CHK_EN the same way the design does.
module tb_inta_cycle_master;
    localparam int PL = 2;
    localparam int PG = 2;
    localparam int RC = 2;
    localparam int L  = 2 * PL + PG;
    localparam int NCYC = 2500;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       INT = 1'b0;
    logic       enable = 1'b0;
    logic       vec_ready = 1'b0;
    logic [7:0] DATA_IN = 8'h00;
    logic       INTA;
    logic [7:0] vec_out;
    logic       vec_valid;
    logic       busy;
    logic       spurious;

    inta_cycle_master #(.PULSE_LOW(PL), .PULSE_GAP(PG), .RECOVER(RC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .INT       (INT),
        .enable    (enable),
        .INTA      (INTA),
        .DATA_IN   (DATA_IN),
        .vec_out   (vec_out),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .busy      (busy),
        .spurious  (spurious)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errs    = 0;

    // Timeline model: edge index since reset release, start edge of the current
    // acknowledge and handshake edge; everything else follows from offsets.
    logic       int_at [0:4095];
    int         e, start, hs, nvec;
    logic       m_inta, m_valid, m_busy, m_spur;
    logic [7:0] m_vec;

    function automatic logic int_hist(input int i);
        return (i < 0) ? 1'b0 : int_at[i];
    endfunction

    task automatic model_reset();
        e = 0; start = -1; hs = -1;
        m_inta = 1'b1; m_valid = 1'b0; m_busy = 1'b0; m_spur = 1'b0; m_vec = 8'h00;
    endtask

    task automatic model_step();
        int off;
        e++;
        int_at[e] = INT;
        // INT seen at edge e-2 is what the synchronised request shows at edge e
        if (start < 0 && int_hist(e - 2) && enable) start = e;
        off = (start >= 0) ? e - start : 0;
        if (start >= 0) begin
            if (hs < 0) begin
                if (off == L) begin
                    m_vec = DATA_IN;
                    m_valid = 1'b1;
`ifdef INTA_SPURIOUS_CHK_EN
                    m_spur = ~int_hist(start + PL + PG - 2);
`endif
                end else if (off > L && vec_ready) begin
                    hs = e;
                    m_valid = 1'b0;
                    m_spur = 1'b0;
                    nvec++;
                    $display("vector %0d accepted: vec=%02h busy_start=%0d", nvec, m_vec, start);
                end
            end else if (e >= hs + RC) begin
                start = -1;
                hs = -1;
            end
        end
        m_inta = ~(start >= 0 && hs < 0 && (off < PL || (off >= PL + PG && off < L)));
        m_busy = (start >= 0);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%02h expected=%02h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("INTA", {7'd0, INTA}, {7'd0, m_inta});
        chk("vec_valid", {7'd0, vec_valid}, {7'd0, m_valid});
        chk("busy", {7'd0, busy}, {7'd0, m_busy});
        chk("spurious", {7'd0, spurious}, {7'd0, m_spur});
        chk("vec_out", vec_out, m_vec);
    endtask

    int  int_run, en_run, rdy_run;
    bit  did_rst;

    task automatic drive_inputs();
        if (int_run == 0) begin
            INT = ($urandom_range(0, 9) < 6);
            int_run = $urandom_range(1, 15);
        end
        if (en_run == 0) begin
            enable = ($urandom_range(0, 9) < 8);
            en_run = $urandom_range(1, 15);
        end
        if (rdy_run == 0) begin
            vec_ready = $urandom_range(0, 1);
            rdy_run = $urandom_range(1, 12);
        end
        int_run--; en_run--; rdy_run--;
        DATA_IN = 8'($urandom);
    endtask

    initial begin
        nvec = 0;
        did_rst = 1'b0;
        model_reset();
        // Reset held with a pending request: outputs must stay at reset values
        INT = 1'b1; enable = 1'b1; vec_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_all();
        end
        rst_n = 1'b1;
        int_run = 6; en_run = 12; rdy_run = 12;
        drive_inputs();
        model_step();
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            check_all();
            if (!did_rst && c > 1200 && start >= 0 && hs < 0 && !m_inta
                && (e - start) >= PL + PG) begin
                // Asynchronous reset during the second pulse
                did_rst = 1'b1;
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all();
                @(negedge clk);
                check_all();
                rst_n = 1'b1;
            end
            drive_inputs();
            model_step();
        end
        if (!did_rst) begin
            errs++;
            $error("FAIL mid_ack2_reset observed=not_reached expected=reached");
        end
        if (nvec < 20) begin
            errs++;
            $error("FAIL handshakes observed=%0d expected>=20", nvec);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
